// File: rtl/cim_host_sequencer.sv
// rtl/cim_host_sequencer.sv - host-side r_w_cim/start/busy command sequencer for the DCIM macro
// One request in flight: encode op, pulse start, track the busy window, capture data, return one response.
module cim_host_sequencer #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_op,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  rsp_cnt,
    output logic [1:0]        rsp_err,
    output logic [1:0]        r_w_cim,
    output logic              start,
    input  logic              busy,
    input  logic              rd_data_enable,
    input  logic              cim_data_enable,
    input  logic [DATA_W-1:0] macro_rdata,
    output logic [DATA_W-1:0] macro_wdata
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_RSVD  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CIM   = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NODATA  = 2'b10;
    localparam logic [1:0] ERR_RSVD    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        RUN,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          err_q, err_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic                start_pulse;
    logic                active;
    logic                expired;
    logic                strobe;
    logic                capture;

    assign active  = (state_q == ISSUE) || (state_q == WAIT_BUSY) || (state_q == RUN);
    // The TIMEOUT-th active cycle is the last one; the next edge lands in RESP.
    assign expired = active && (timer_q == TMR_W'(TIMEOUT - 1));

    assign strobe  = ((op_q == OP_READ) && rd_data_enable) ||
                     ((op_q == OP_CIM)  && cim_data_enable);
    assign capture = strobe && ((state_q == WAIT_BUSY) || ((state_q == RUN) && busy));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        timer_d     = timer_q;
        start_pulse = 1'b0;

        if (active) begin
            timer_d = timer_q + 1'b1;
        end

        if (capture) begin
            data_d = macro_rdata;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    wdata_d = req_wdata;
                    data_d  = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    if (req_op == OP_RSVD) begin
                        err_d   = ERR_RSVD;
                        state_d = RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!busy) begin
                    start_pulse = 1'b1;
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!busy) begin
                    state_d = RESP;
                    err_d   = (((op_q == OP_READ) || (op_q == OP_CIM)) && (cnt_q == '0))
                              ? ERR_NODATA : ERR_OK;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    op_d    = OP_RSVD;
                    wdata_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout wins over every other outcome, including a start due this cycle.
        if (expired) begin
            state_d     = RESP;
            err_d       = ERR_TIMEOUT;
            start_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            op_q    <= OP_RSVD;
            wdata_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= ERR_OK;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_op      = op_q;
    assign rsp_data    = data_q;
    assign rsp_cnt     = cnt_q;
    assign rsp_err     = err_q;
    assign r_w_cim     = op_q;
    assign macro_wdata = wdata_q;
    assign start       = start_pulse;

endmodule

// File: tb/tb_cim_host_sequencer.sv
// tb/tb_cim_host_sequencer.sv - directed self-checking bench for cim_host_sequencer
module tb_cim_host_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_cnt;
    logic [1:0]  rsp_err;
    logic [1:0]  r_w_cim;
    logic        start;
    logic        busy;
    logic        rd_data_enable;
    logic        cim_data_enable;
    logic [63:0] macro_rdata;
    logic [63:0] macro_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    cim_host_sequencer #(
        .DATA_W  (64),
        .TIMEOUT (16),
        .CNT_W   (4)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_op          (rsp_op),
        .rsp_data        (rsp_data),
        .rsp_cnt         (rsp_cnt),
        .rsp_err         (rsp_err),
        .r_w_cim         (r_w_cim),
        .start           (start),
        .busy            (busy),
        .rd_data_enable  (rd_data_enable),
        .cim_data_enable (cim_data_enable),
        .macro_rdata     (macro_rdata),
        .macro_wdata     (macro_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input logic [1:0] op, input logic [63:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_wdata = wd;
        cyc();
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_wdata = '0;
        #1;
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
    endtask

    initial begin
        rst_b           = 1'b0;
        req_valid       = 1'b0;
        req_op          = 2'b00;
        req_wdata       = '0;
        rsp_ready       = 1'b0;
        busy            = 1'b0;
        rd_data_enable  = 1'b0;
        cim_data_enable = 1'b0;
        macro_rdata     = '0;

        cyc();
        cyc();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_start", start, 0);
        chk("rst_r_w_cim", r_w_cim, 0);
        chk("rst_macro_wdata", macro_wdata, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_cnt", rsp_cnt, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_op", rsp_op, 0);
        rst_b = 1'b1;
        cyc();

        // write, busy high for three cycles
        accept(2'b10, 64'hA5A5_0000_FFFF_1234);
        chk("wr_start", start, 1);
        chk("wr_r_w_cim", r_w_cim, 2'b10);
        chk("wr_req_ready", req_ready, 0);
        chk("wr_wdata", macro_wdata, 64'hA5A5_0000_FFFF_1234);
        cyc();
        busy = 1'b1;
        #1;
        chk("wr_start_once", start, 0);
        cyc();
        cyc();
        cyc();
        busy = 1'b0;
        #1;
        chk("wr_wdata_held", macro_wdata, 64'hA5A5_0000_FFFF_1234);
        chk("wr_no_rsp_yet", rsp_valid, 0);
        cyc();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_op", rsp_op, 2'b10);
        chk("wr_rsp_data", rsp_data, 0);
        chk("wr_rsp_err", rsp_err, 2'b00);
        handshake();
        chk("wr_done_valid", rsp_valid, 0);
        chk("wr_done_rwcim", r_w_cim, 0);
        chk("wr_done_ready", req_ready, 1);

        // read with one rd_data_enable strobe in RUN
        accept(2'b01, 64'h0);
        chk("rd_start", start, 1);
        cyc();
        busy = 1'b1;
        cyc();
        rd_data_enable = 1'b1;
        macro_rdata    = 64'h0123_4567_89AB_CDEF;
        cyc();
        rd_data_enable = 1'b0;
        macro_rdata    = '0;
        cyc();
        busy = 1'b0;
        cyc();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_data", rsp_data, 64'h0123_4567_89AB_CDEF);
        chk("rd_rsp_cnt", rsp_cnt, 1);
        chk("rd_rsp_err", rsp_err, 2'b00);
        chk("rd_rsp_op", rsp_op, 2'b01);
        handshake();

        // CIM with two separate strobes, last one wins
        accept(2'b11, 64'h0);
        cyc();
        busy = 1'b1;
        cyc();
        chk("cim_r_w_cim_run", r_w_cim, 2'b11);
        cim_data_enable = 1'b1;
        macro_rdata     = 64'h11;
        cyc();
        cim_data_enable = 1'b0;
        cyc();
        cim_data_enable = 1'b1;
        macro_rdata     = 64'h22;
        cyc();
        cim_data_enable = 1'b0;
        macro_rdata     = '0;
        busy            = 1'b0;
        cyc();
        chk("cim_rsp_valid", rsp_valid, 1);
        chk("cim_rsp_data", rsp_data, 64'h22);
        chk("cim_rsp_cnt", rsp_cnt, 2);
        chk("cim_rsp_err", rsp_err, 2'b00);
        handshake();

        // busy already high at issue for five cycles
        busy = 1'b1;
        accept(2'b10, 64'h5);
        for (int i = 0; i < 5; i++) begin
            chk("bsy_start_withheld", start, 0);
            cyc();
        end
        busy = 1'b0;
        #1;
        chk("bsy_start_pulse", start, 1);
        cyc();
        chk("bsy_start_single", start, 0);
        busy = 1'b1;
        cyc();
        busy = 1'b0;
        cyc();
        chk("bsy_rsp_valid", rsp_valid, 1);
        chk("bsy_rsp_err", rsp_err, 2'b00);
        handshake();

        // busy stuck high: timeout after 16 active cycles
        busy = 1'b1;
        accept(2'b01, 64'h0);
        chk("to_no_start", start, 0);
        repeat (15) cyc();
        chk("to_not_yet", rsp_valid, 0);
        chk("to_start_never", start, 0);
        cyc();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 2'b01);
        chk("to_rsp_op", rsp_op, 2'b01);
        busy = 1'b0;
        handshake();

        // read with no strobe
        accept(2'b01, 64'h0);
        cyc();
        busy = 1'b1;
        cyc();
        busy = 1'b0;
        cyc();
        chk("nd_rsp_valid", rsp_valid, 1);
        chk("nd_rsp_err", rsp_err, 2'b10);
        chk("nd_rsp_cnt", rsp_cnt, 0);
        handshake();

        // reserved op goes straight to a response, no start
        accept(2'b00, 64'h77);
        chk("rsv_start", start, 0);
        chk("rsv_rsp_valid", rsp_valid, 1);
        chk("rsv_rsp_err", rsp_err, 2'b11);
        chk("rsv_rsp_op", rsp_op, 2'b00);
        cyc();
        chk("rsv_rsp_hold", rsp_valid, 1);
        chk("rsv_start_hold", start, 0);
        handshake();
        chk("rsv_done_ready", req_ready, 1);

        // asynchronous reset during RUN, then a clean read
        accept(2'b11, 64'h99);
        cyc();
        busy = 1'b1;
        cyc();
        cim_data_enable = 1'b1;
        macro_rdata     = 64'h55;
        cyc();
        cim_data_enable = 1'b0;
        #1;
        chk("mr_cnt_before", rsp_cnt, 1);
        rst_b = 1'b0;
        #1;
        chk("mr_req_ready", req_ready, 1);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_r_w_cim", r_w_cim, 0);
        chk("mr_start", start, 0);
        chk("mr_macro_wdata", macro_wdata, 0);
        chk("mr_rsp_data", rsp_data, 0);
        chk("mr_rsp_cnt", rsp_cnt, 0);
        chk("mr_rsp_err", rsp_err, 0);
        busy        = 1'b0;
        macro_rdata = '0;
        cyc();
        rst_b = 1'b1;
        cyc();
        accept(2'b01, 64'h0);
        chk("pr_start", start, 1);
        cyc();
        busy           = 1'b1;
        rd_data_enable = 1'b1;
        macro_rdata    = 64'hDEAD_BEEF_CAFE_F00D;
        cyc();
        rd_data_enable = 1'b0;
        macro_rdata    = '0;
        cyc();
        busy = 1'b0;
        cyc();
        chk("pr_rsp_valid", rsp_valid, 1);
        chk("pr_rsp_data", rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("pr_rsp_cnt", rsp_cnt, 1);
        chk("pr_rsp_err", rsp_err, 2'b00);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
